serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `a - b` LSB-first, one bit per clock, through a single one-bit full-subtract cell and a borrow flip-flop. It accepts operands over a valid/ready handshake and returns the difference, final borrow and optional signed overflow over a second valid/ready handshake. It sits directly downstream of the operand source and wraps the team's one-bit subtract cell, trading latency for area in the datapath.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_sub_cell.sv | 25 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_subtractor_pkg;

  // Smallest operand width the datapath and counter are built for.
  localparam int MIN_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_sub_cell.sv
// rtl/serial_subtractor_sub_cell.sv - combinational one-bit full subtractor (sub_cell)
module sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First half-subtract: a - b.
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // Second half-subtract: (a - b) - bin.
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  // A borrow from either stage propagates out.
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first; SERIAL_SUBTRACTOR_OVF_EN enables signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             borrow_q;
  logic             out_valid_q;
  logic             cell_d;
  logic             cell_bout;
  logic             last_shift;

  sub_cell u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_shift = (state == SHIFT) && (cnt == LAST_BIT);

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign diff      = res;
  assign borrow    = borrow_q;

  // FSM, operand shift registers, result register, borrow and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      res         <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a     <= a;
            sh_b     <= b;
            borrow_q <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          res      <= {cell_d, res[WIDTH-1:1]};
          sh_a     <= sh_a >> 1;
          sh_b     <= sh_b >> 1;
          borrow_q <= cell_bout;
          if (cnt == LAST_BIT) begin
            cnt         <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Capture operand sign bits at load; resolve overflow on the final shift edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if ((state == IDLE) && in_valid) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_shift) begin
      ovf_q <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_last_shift;
  assign unused_last_shift = last_shift;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int WIDTH = 8;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL rst_diff got %h want 00", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_bad++; $display("FAIL rst_borrow got %b want 0", borrow); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  // One full operation: accept, measure latency, check result, hand off.
  task automatic test_vector(input logic [7:0] va, input logic [7:0] vb,
                             input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~va; b = ~vb;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    n_cmp++; if (n != WIDTH) begin n_bad++; $display("FAIL latency %h-%h got %0d want %0d", va, vb, n, WIDTH); end
    n_cmp++; if (diff !== ed) begin n_bad++; $display("FAIL diff %h-%h got %h want %h", va, vb, diff, ed); end
    n_cmp++; if (borrow !== eb) begin n_bad++; $display("FAIL borrow %h-%h got %b want %b", va, vb, borrow, eb); end
    n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL ovf %h-%h got %b want %b", va, vb, ovf, eo); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL handoff %h-%h got out_valid=%b in_ready=%b want 0/1", va, vb, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    n_cmp++; if (diff !== 8'h00 || borrow !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL bp_result got %h/%b/%b want 00/0/0", diff, borrow, ovf);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || diff !== 8'h00 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold cycle %0d got out_valid=%b diff=%h in_ready=%b want 1/00/0", i, out_valid, diff, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_release got out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    a = 8'h40; b = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_rst_idle got busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_no_valid got %0d pulses want 0", seen); end
    test_vector(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc_t [$];
    int results;
    in_valid = 1'b1;
    out_ready = 1'b1;
    results = 0;
    for (int t = 0; t < 40; t++) begin
      if (in_ready) begin
        a = 8'h35; b = 8'h12;
        acc_t.push_back(t);
      end else begin
        a = 8'hAA; b = 8'h55;
      end
      if (out_valid) begin
        results++;
        n_cmp++; if (diff !== 8'h23 || borrow !== 1'b0) begin
          n_bad++; $display("FAIL b2b_result %0d got %h/%b want 23/0", results, diff, borrow);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (acc_t.size() < 4) begin n_bad++; $display("FAIL b2b_accepts got %0d want >=4", acc_t.size()); end
    for (int i = 1; i < acc_t.size(); i++) begin
      n_cmp++; if (acc_t[i] - acc_t[i-1] != WIDTH + 2) begin
        n_bad++; $display("FAIL b2b_spacing %0d got %0d want %0d", i, acc_t[i] - acc_t[i-1], WIDTH + 2);
      end
    end
    n_cmp++; if (results < 3) begin n_bad++; $display("FAIL b2b_results got %0d want >=3", results); end
  endtask

  initial begin
    test_reset();
    test_vector(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    test_vector(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    test_vector(8'h80, 8'h01, 8'h7F, 1'b0, OVF_ON);
    test_vector(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
